// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared encodings for the FIFO write-port arbiter: FSM states and owner codes.
package fifo_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLock0 = 2'd1,
    StLock1 = 2'd2
  } state_e;

  localparam logic [1:0] OwnerNone = 2'b00;
  localparam logic [1:0] OwnerSrc0 = 2'b01;
  localparam logic [1:0] OwnerSrc1 = 2'b10;

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to rr_next.
module fifo_wr_arbiter_rr (
  input  logic [1:0] req,
  input  logic       rr_next,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = rr_next ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing the BRAM FIFO write port between two byte sources.
// Optional statistics counters are built when FIFO_WR_ARBITER_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_PKT    = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_valid,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_last,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_last,
  output logic                  s1_ready,
  output logic                  fifo_wr_dv,
  output logic [DATA_WIDTH-1:0] fifo_wr_DATA,
  input  logic                  fifo_wr_full,
`ifdef FIFO_WR_ARBITER_STATS_EN
  output logic [CNT_WIDTH-1:0]  s0_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  s1_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
`endif
  output logic [1:0]            owner,
  output logic                  wdog_err
);

  localparam int unsigned CW = $clog2(MAX_PKT + 1);
  localparam logic [CW-1:0] MaxPktC = CW'(MAX_PKT);

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wdog_q, wdog_d;
  logic [1:0]    grant;
  logic          acc0, acc1;

  fifo_wr_arbiter_rr u_rr (
    .req     ({s1_valid, s0_valid}),
    .rr_next (rr_q),
    .grant   (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
    end
  end

  // Readies are gated by rst so an in-flight packet sees its lock vanish immediately.
  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    owner    = OwnerNone;
    case (state_q)
      StIdle: begin
        s0_ready = grant[0] & ~fifo_wr_full;
        s1_ready = grant[1] & ~fifo_wr_full;
      end
      StLock0: begin
        s0_ready = ~fifo_wr_full;
        owner    = OwnerSrc0;
      end
      StLock1: begin
        s1_ready = ~fifo_wr_full;
        owner    = OwnerSrc1;
      end
      default: ;
    endcase
    if (rst) begin
      s0_ready = 1'b0;
      s1_ready = 1'b0;
    end
  end

  assign acc0         = s0_valid & s0_ready;
  assign acc1         = s1_valid & s1_ready;
  assign fifo_wr_dv   = acc0 | acc1;
  assign fifo_wr_DATA = acc0 ? s0_data : (acc1 ? s1_data : '0);
  assign wdog_err     = wdog_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    wdog_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (acc0) begin
          if (s0_last) begin
            rr_d = 1'b1;
          end else begin
            state_d = StLock0;
            cnt_d   = CW'(1);
          end
        end else if (acc1) begin
          if (s1_last) begin
            rr_d = 1'b0;
          end else begin
            state_d = StLock1;
            cnt_d   = CW'(1);
          end
        end
      end
      StLock0, StLock1: begin
        if (acc0 | acc1) begin
          if ((acc0 & s0_last) | (acc1 & s1_last)) begin
            state_d = StIdle;
            rr_d    = acc0;
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == MaxPktC) begin
            state_d = StIdle;
            rr_d    = acc0;
            cnt_d   = '0;
            wdog_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_pkt_cnt <= '0;
      s1_pkt_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (acc0 & s0_last) s0_pkt_cnt <= s0_pkt_cnt + CNT_WIDTH'(1);
      if (acc1 & s1_last) s1_pkt_cnt <= s1_pkt_cnt + CNT_WIDTH'(1);
      if ((s0_valid | s1_valid) & fifo_wr_full) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the synchronous BRAM FIFO between two byte-stream sources.
- Source 0 is the sniffed ULPI data path; source 1 is the event/timestamp path.
- Arbitration is packet-locked round-robin: once a source wins, it owns the port until its `last` beat is accepted or a length watchdog fires.
- Sits directly in front of the FIFO's wr_dv / wr_DATA / wr_full port.

Parameters:
- DATA_WIDTH, 8, width of each source beat and of the FIFO word.
- MAX_PKT, 64, maximum beats per grant before the watchdog forces release (2 to 2^16-1).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  reference clock, all logic on posedge.
- rst  in  1  reset; asynchronous and active-high.
- s0_valid  in  1  source 0 beat valid.
- s0_data  in  DATA_WIDTH  source 0 beat.
- s0_last  in  1  source 0 final beat of packet.
- s0_ready  out  1  source 0 beat accepted this cycle when s0_valid is also high.
- s1_valid  in  1  source 1 beat valid.
- s1_data  in  DATA_WIDTH  source 1 beat.
- s1_last  in  1  source 1 final beat of packet.
- s1_ready  out  1  source 1 beat accepted this cycle when s1_valid is also high.
- fifo_wr_dv  out  1  FIFO write strobe.
- fifo_wr_DATA  out  DATA_WIDTH  FIFO write data.
- fifo_wr_full  in  1  FIFO full flag.
- owner  out  2  current lock: 00 none, 01 src0, 10 src1.
- wdog_err  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (async, rst=1): state IDLE, rr_next=0 (source 0 favoured), beat counter=0.
  - Outputs at reset: owner=00, wdog_err=0, s0_ready=0, s1_ready=0, fifo_wr_dv=0.
- Datapath is zero-latency combinational pass-through:
  - fifo_wr_dv = (s0_valid & s0_ready) | (s1_valid & s1_ready).
  - fifo_wr_DATA = data of the accepted source; 0 when no beat is accepted.
  - At most one ready is high in any cycle.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE:
  - Winner = the only valid source; if both are valid, winner = rr_next.
  - winner_ready = !fifo_wr_full. The first beat is accepted in the same cycle.
  - If the accepted beat has last=1: stay IDLE, rr_next = other source.
  - Else: go to LOCKn, beat counter = 1.
  - If the FIFO is full: no ready, stay IDLE, no state change.
- LOCKn:
  - sn_ready = !fifo_wr_full; the other source's ready = 0 regardless of its valid.
  - Each accepted beat increments the beat counter.
  - Accepted beat with last=1: go to IDLE, rr_next = other source, counter cleared.
  - Accepted beat without last where counter+1 == MAX_PKT: go to IDLE, pulse wdog_err next cycle, rr_next = other source, counter cleared. The source's remaining beats form a new packet.
  - Valid low or FIFO full: hold lock, counter unchanged. No idle timeout.
- Full FIFO: never assert fifo_wr_dv while fifo_wr_full=1. Beats stall and are never dropped.
- Reset mid-packet: lock released immediately. The source sees ready=0 and must restart its packet.
- Counter width: $clog2(MAX_PKT+1). Comparisons are unsigned.
- owner is registered state (01/10 in LOCK0/LOCK1). It does not reflect single-beat packets accepted in IDLE.

Optional Feature:
- Macro: FIFO_WR_ARBITER_STATS_EN.
- With the macro, three extra output ports:
  - s0_pkt_cnt [CNT_WIDTH]: increments on each accepted last beat of source 0.
  - s1_pkt_cnt [CNT_WIDTH]: same for source 1.
  - stall_cnt [CNT_WIDTH]: increments each cycle some valid is high and fifo_wr_full=1.
  - All three wrap modulo 2^CNT_WIDTH, reset to 0, and are counted on the cycle after the event.
- Without the macro: the ports are absent and no counter logic exists.

Decomposition:
- Shared package/include file: state encodings (IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2) and owner encodings.
- Natural sub-module: fifo_wr_arbiter_rr, the 2-way round-robin pick. Inputs: req[1:0], rr_next. Output: one-hot grant. It is reused later for read-side sharing.
- FSM, watchdog and mux stay in the top module.

Test Plan:
- s0 sends 3-beat packet 0xA1,0xA2,0xA3 (last on 3rd), FIFO empty → fifo_wr_dv high 3 consecutive cycles with those bytes; owner=01 after beat 1; IDLE after beat 3.
- s0 and s1 both valid from IDLE, 1-beat packets each, repeated 4 times → grants alternate s0,s1,s0,s1 …; no cycle with both readies high.
- s1 locked mid-packet, s0 valid continuously → s0_ready stays 0 until s1's last beat is accepted; s0 wins the next cycle.
- fifo_wr_full=1 for 5 cycles during LOCK0 → fifo_wr_dv=0 and s0_ready=0 those cycles; lock and counter held; the stalled byte is written the first cycle full drops.
- MAX_PKT=4, s0 sends 6 beats with no last → 4 beats written, wdog_err pulses once, s1 (valid) wins next, s0 resumes after.
- rst asserted asynchronously mid-LOCK1 → owner=00 and all readies 0 immediately, without waiting for a clk edge; rr_next=0 after release.
